multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle control FSM that sequences the 24-bit CPU datapath: it receives the 4-bit opcode from the datapath and drives every datapath control strobe (RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp) plus IR/PC write enables. It replaces single-cycle combinational decode with a FETCH/DECODE/EXEC/MEM/WB sequence, waits on a data-memory ready handshake, flags illegal opcodes and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- opcode  in  4  instruction[23:20] from datapath IR
- MemReady  in  1  data memory has completed current read/write
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC from datapath next-PC mux
- RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 sub (BEQ compare), 10 R-type funct decode, 11 I-type opcode decode
- Illegal  out  1  one-cycle pulse: unsupported opcode retired as NOP
- State  out  3  current state, debug
- InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Opcodes: 0000 R-type; 0001 ADDI, 0010 SUBI, 0011 ANDI, 0100 ORI (I-ALU); 1000 LW; 1001 SW; 1010 BEQ; 1100 J; all others illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; values 5-7 unreachable, recover to FETCH next edge.
- op_q: opcode latched on DECODE->EXEC edge; EXEC/MEM/WB decode op_q only, never live opcode.
- Outputs are Moore (state + op_q) except PCWrite in MEM. Unlisted outputs are 0.
- FETCH: IRWrite=1 -> DECODE.
- DECODE: no strobes -> EXEC.
- EXEC R-type: ALUOp=10 -> WB. I-ALU: ALUSrc=1, ALUOp=11 -> WB. LW/SW: ALUSrc=1, ALUOp=00 -> MEM. BEQ: ALUOp=01, Branch=1, PCWrite=1 -> FETCH. J: Jump=1, PCWrite=1 -> FETCH. Illegal: PCWrite=1, Illegal=1 -> FETCH.
- MEM (ALUSrc=1, ALUOp=00 held): LW MemRead=1; stays until MemReady=1, then -> WB. SW MemWrite=1; PCWrite=MemReady; stays until MemReady=1, then -> FETCH.
- WB: RegWrite=1, PCWrite=1 -> FETCH; R-type adds RegDst=1, ALUOp=10; I-ALU adds ALUSrc=1, ALUOp=11; LW adds MemToReg=1 (MemRead=0).
- InstrCount increments on every clock edge where PCWrite=1 (includes illegal NOPs); FFFF -> 0000 for CNT_W=16.
- MemReady is ignored outside MEM.

## Timing
- Resetn low (async): state=FETCH, op_q=0000, InstrCount=0, all outputs forced 0 (including IRWrite) while Resetn low; first IRWrite=1 in the cycle after the first rising edge following Resetn deassertion... precisely: IRWrite=1 combinationally once Resetn is high in FETCH.
- Reset mid-instruction (any state, including MEM wait): strobes drop immediately, no PCWrite/RegWrite/MemWrite issued, instruction abandoned.
- Latency (cycles, MemReady=1 on first MEM cycle): BEQ/J/illegal 3; R/I-ALU 4; SW 4; LW 5. Each MEM cycle with MemReady=0 adds one cycle.
- MemRead/MemWrite remain asserted and stable for every MEM cycle until the MemReady=1 edge; deassert the following cycle.
- RegWrite and PCWrite are single-cycle per instruction; exactly one PCWrite per instruction.
- Illegal is high only in EXEC of the illegal instruction.

## Test plan
- Reset then opcode=0000 held: State 0,1,2,4,0; RegDst=1/RegWrite=1/PCWrite=1 only in WB, ALUOp=10 in EXEC and WB; InstrCount=1 after 4 cycles.
- opcode=1000 (LW), MemReady=0 for 3 MEM cycles then 1: MemRead high 4 cycles, then WB with MemToReg=1, RegWrite=1; total 8 cycles; InstrCount +1.
- opcode=1001 (SW), MemReady=1 first MEM cycle: MemWrite and PCWrite high in cycle 4 only, RegWrite never high; back to FETCH.
- opcode=1010 then 1100: BEQ EXEC shows Branch=1, ALUOp=01, PCWrite=1; J EXEC shows Jump=1, PCWrite=1; each 3 cycles, InstrCount +2.
- opcode=0111 (illegal): Illegal=1 and PCWrite=1 in EXEC, no other strobes, InstrCount +1; change opcode during EXEC/WB of ADDI: outputs unaffected (op_q held).
- Resetn pulsed low in MEM of SW with MemReady=0: MemWrite drops asynchronously, InstrCount=0, after release State=0 with IRWrite=1; preload count near 2^16-1 via 65535 J instructions and verify wrap to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 24-bit CPU datapath.
// The instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB. The opcode is
// captured once, on the DECODE->EXEC edge, so a datapath that changes the live
// opcode later cannot disturb an instruction that is already in flight.
// Strobes are decoded from the current state and the captured opcode. The only
// exception is PCWrite in MEM, which follows MemReady. Every output is held at
// 0 while Resetn is low. Retired instructions are counted on each PCWrite.
module multicycle_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [3:0]       opcode,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegDst,
    output logic             Jump,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } aluop_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1010;
    localparam logic [3:0] OP_J     = 4'b1100;

    state_e     state;
    logic [3:0] op_q;

    // Opcode classes, always taken from the captured opcode.
    logic is_rtype, is_ialu, is_lw, is_sw, is_beq, is_j;

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_ialu  = (op_q >= 4'b0001) && (op_q <= 4'b0100);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_j     = (op_q == OP_J);

    // State sequencing, opcode capture and the retired-instruction counter.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values. This matters for InstrCount, which looks at the
    // PCWrite decoded from the state that is being left.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_FETCH;
            op_q       <= 4'b0000;
            InstrCount <= '0;
        end else begin
            if (PCWrite) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_rtype || is_ialu) begin
                        state <= S_WB;
                    end else if (is_lw || is_sw) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_FETCH;  // BEQ, J and illegal opcodes finish here
                    end
                end
                S_MEM: begin
                    if (MemReady) begin
                        state <= is_lw ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_FETCH;  // the unused codes 5-7 recover to FETCH
            endcase
        end
    end

    // Datapath strobes: Moore decode of state and op_q, held at 0 during reset.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegDst   = 1'b0;
        Jump     = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemToReg = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = ALU_ADD;
        Illegal  = 1'b0;
        if (Resetn) begin
            case (state)
                S_FETCH:  IRWrite = 1'b1;
                S_DECODE: ;
                S_EXEC: begin
                    if (is_rtype) begin
                        ALUOp = ALU_FUNCT;
                    end else if (is_ialu) begin
                        ALUSrc = 1'b1;
                        ALUOp  = ALU_IMM;
                    end else if (is_lw || is_sw) begin
                        ALUSrc = 1'b1;  // address = base + offset
                    end else if (is_beq) begin
                        ALUOp   = ALU_SUB;
                        Branch  = 1'b1;
                        PCWrite = 1'b1;
                    end else if (is_j) begin
                        Jump    = 1'b1;
                        PCWrite = 1'b1;
                    end else begin
                        PCWrite = 1'b1;  // retire the illegal opcode as a NOP
                        Illegal = 1'b1;
                    end
                end
                S_MEM: begin
                    ALUSrc = 1'b1;  // keep the address stable while memory works
                    if (is_lw) begin
                        MemRead = 1'b1;
                    end else begin
                        MemWrite = 1'b1;
                        PCWrite  = MemReady;  // a store retires on its ready cycle
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    if (is_rtype) begin
                        RegDst = 1'b1;
                        ALUOp  = ALU_FUNCT;
                    end else if (is_ialu) begin
                        ALUSrc = 1'b1;
                        ALUOp  = ALU_IMM;
                    end else begin
                        MemToReg = 1'b1;  // only a load reaches WB otherwise
                    end
                end
                default: ;
            endcase
        end
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit.
// For each instruction, the driver builds the expected output vector of every
// cycle from the opcode rules and pushes it into a queue. A monitor samples
// the DUT on every falling edge while entries are pending, pops the next entry
// and compares. A second instance with a 4-bit counter runs on the same inputs.
// That instance wraps every 16 retirements, so counter rollover is exercised
// many times within a short run.
module tb_multicycle_control_unit;

    logic        Clock;
    logic        Resetn;
    logic [3:0]  opcode;
    logic        MemReady;

    logic        IRWrite, PCWrite, RegDst, Jump, Branch, MemRead, MemToReg;
    logic        MemWrite, ALUSrc, RegWrite, Illegal;
    logic [1:0]  ALUOp;
    logic [2:0]  State;
    logic [15:0] InstrCount;

    logic        s_irwrite, s_pcwrite, s_regdst, s_jump, s_branch, s_memread, s_memtoreg;
    logic        s_memwrite, s_alusrc, s_regwrite, s_illegal;
    logic [1:0]  s_aluop;
    logic [2:0]  s_state;
    logic [3:0]  s_count;

    multicycle_control_unit #(.CNT_W(16)) dut (
        .Clock(Clock), .Resetn(Resetn), .opcode(opcode), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst), .Jump(Jump),
        .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .Illegal(Illegal),
        .State(State), .InstrCount(InstrCount)
    );

    multicycle_control_unit #(.CNT_W(4)) dut_narrow (
        .Clock(Clock), .Resetn(Resetn), .opcode(opcode), .MemReady(MemReady),
        .IRWrite(s_irwrite), .PCWrite(s_pcwrite), .RegDst(s_regdst), .Jump(s_jump),
        .Branch(s_branch), .MemRead(s_memread), .MemToReg(s_memtoreg), .MemWrite(s_memwrite),
        .ALUSrc(s_alusrc), .RegWrite(s_regwrite), .ALUOp(s_aluop), .Illegal(s_illegal),
        .State(s_state), .InstrCount(s_count)
    );

    typedef struct packed {
        logic        irwrite;
        logic        pcwrite;
        logic        regdst;
        logic        jump;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        memwrite;
        logic        alusrc;
        logic        regwrite;
        logic [1:0]  aluop;
        logic        illegal;
        logic [2:0]  state;
        logic [15:0] count;
        logic [3:0]  count_n;
    } out_t;

    out_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int unsigned retired;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t a;
        a.irwrite  = IRWrite;
        a.pcwrite  = PCWrite;
        a.regdst   = RegDst;
        a.jump     = Jump;
        a.branch   = Branch;
        a.memread  = MemRead;
        a.memtoreg = MemToReg;
        a.memwrite = MemWrite;
        a.alusrc   = ALUSrc;
        a.regwrite = RegWrite;
        a.aluop    = ALUOp;
        a.illegal  = Illegal;
        a.state    = State;
        a.count    = InstrCount;
        a.count_n  = s_count;
        return a;
    endfunction

    // Reference model. Given a phase of an instruction (0 fetch, 1 decode,
    // 2 execute, 3 memory, 4 write-back), return the expected outputs.
    function automatic out_t expect_cycle(input int phase, input logic [3:0] opc,
                                          input bit mem_done, input int unsigned n);
        out_t e;
        bit   r, i, lw, sw, beq, j;
        e         = '0;
        e.state   = 3'(phase);
        e.count   = 16'(n);
        e.count_n = 4'(n);
        r   = (opc == 4'd0);
        i   = (opc >= 4'd1 && opc <= 4'd4);
        lw  = (opc == 4'd8);
        sw  = (opc == 4'd9);
        beq = (opc == 4'd10);
        j   = (opc == 4'd12);
        case (phase)
            0: e.irwrite = 1'b1;
            2: begin
                if (r)             e.aluop = 2'b10;
                else if (i)        begin e.alusrc = 1'b1; e.aluop = 2'b11; end
                else if (lw || sw) e.alusrc = 1'b1;
                else if (beq)      begin e.aluop = 2'b01; e.branch = 1'b1; e.pcwrite = 1'b1; end
                else if (j)        begin e.jump = 1'b1; e.pcwrite = 1'b1; end
                else               begin e.pcwrite = 1'b1; e.illegal = 1'b1; end
            end
            3: begin
                e.alusrc = 1'b1;
                if (lw) e.memread = 1'b1;
                else begin e.memwrite = 1'b1; e.pcwrite = mem_done; end
            end
            4: begin
                e.regwrite = 1'b1;
                e.pcwrite  = 1'b1;
                if (r)      begin e.regdst = 1'b1; e.aluop = 2'b10; end
                else if (i) begin e.alusrc = 1'b1; e.aluop = 2'b11; end
                else        e.memtoreg = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Call in the FETCH cycle, shortly after a rising edge. The real opcode is
    // driven only in DECODE; every other cycle gets a random opcode, and
    // MemReady is random outside the memory phase.
    task automatic run_instr(input logic [3:0] opc, input int waits);
        bit has_mem;
        bit has_wb;
        has_mem = (opc == 4'd8 || opc == 4'd9);
        has_wb  = (opc <= 4'd4 || opc == 4'd8);
        exp_q.push_back(expect_cycle(0, opc, 1'b0, retired));
        exp_q.push_back(expect_cycle(1, opc, 1'b0, retired));
        exp_q.push_back(expect_cycle(2, opc, 1'b0, retired));
        if (has_mem) begin
            for (int m = 0; m <= waits; m++) begin
                exp_q.push_back(expect_cycle(3, opc, m == waits, retired));
            end
        end
        if (has_wb) exp_q.push_back(expect_cycle(4, opc, 1'b0, retired));

        opcode = 4'($urandom); MemReady = 1'($urandom);
        @(posedge Clock); #1;
        opcode = opc;          MemReady = 1'($urandom);
        @(posedge Clock); #1;
        opcode = 4'($urandom); MemReady = 1'($urandom);
        @(posedge Clock); #1;
        if (has_mem) begin
            for (int m = 0; m <= waits; m++) begin
                opcode   = 4'($urandom);
                MemReady = (m == waits);
                @(posedge Clock); #1;
            end
        end
        if (has_wb) begin
            opcode = 4'($urandom); MemReady = 1'($urandom);
            @(posedge Clock); #1;
        end
        retired++;
    endtask

    // Abort a store that is stalled in MEM by pulsing reset.
    task automatic reset_in_mem();
        opcode = 4'($urandom); MemReady = 1'b0;
        @(posedge Clock); #1;
        opcode = 4'b1001;
        @(posedge Clock); #1;
        opcode = 4'($urandom);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check("SW stalled in MEM", 64'(sample()), 64'(expect_cycle(3, 4'b1001, 1'b0, retired)));
        #2 Resetn = 1'b0;
        retired = 0;
        #1 check("reset asserted in MEM", 64'(sample()), 64'(out_t'('0)));
        MemReady = 1'b1;
        @(posedge Clock); #1;
        check("reset held across edge", 64'(sample()), 64'(out_t'('0)));
        Resetn = 1'b1;
        #1 check("after reset release", 64'(sample()), 64'(expect_cycle(0, 4'b0, 1'b0, retired)));
    endtask

    // Monitor: one expected vector per cycle while entries are pending.
    initial begin
        out_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle %0d phase %0d", cyc, e.state), 64'(sample()), 64'(e));
            end
        end
    end

    initial begin
        cyc      = 0;
        n_cmp    = 0;
        n_err    = 0;
        retired  = 0;
        Resetn   = 1'b0;
        opcode   = 4'b0000;
        MemReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        opcode   = 4'($urandom);
        MemReady = 1'b1;
        #1 check("outputs during reset", 64'(sample()), 64'(out_t'('0)));
        Resetn = 1'b1;
        #1 check("IRWrite after release", 64'(sample()), 64'(expect_cycle(0, 4'b0, 1'b0, 0)));

        run_instr(4'b0000, 0);  // R-type
        run_instr(4'b1000, 3);  // LW with three stalled MEM cycles
        run_instr(4'b1001, 0);  // SW ready at once
        run_instr(4'b1010, 0);  // BEQ
        run_instr(4'b1100, 0);  // J
        run_instr(4'b0111, 0);  // illegal
        run_instr(4'b0001, 0);  // ADDI with the opcode scrambled after DECODE
        for (int k = 0; k < 300; k++) begin
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        reset_in_mem();
        for (int k = 0; k < 20; k++) begin
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clock);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
